// File: rtl/mips_alu_pkg.sv
// Shared ALU-issue definitions: ALU control / ALUOp codes, funct constants,
// forward-select encoding and the registered ALU decode helper.
package mips_alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_ctl_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_ORI   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic     illegal;
    alu_ctl_e ctl;
  } alu_dec_t;

  // Unsupported R-type funct still issues as ADD; the caller suppresses the write.
  function automatic alu_dec_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_dec_t d;
    d.illegal = 1'b0;
    d.ctl     = ALU_ADD;
    case (op)
      OP_ADD: d.ctl = ALU_ADD;
      OP_SUB: d.ctl = ALU_SUB;
      OP_ORI: d.ctl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: d.ctl = ALU_ADD;
          FUNCT_SUB: d.ctl = ALU_SUB;
          FUNCT_AND: d.ctl = ALU_AND;
          FUNCT_OR:  d.ctl = ALU_OR;
          default: begin
            d.ctl     = ALU_ADD;
            d.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_forward_sel.sv
// forward_sel: 2-bit operand forward select for one source register specifier.
// EX/MEM beats MEM/WB; register 0 never forwards.
module forward_sel
  import mips_alu_pkg::*;
#(
  parameter int REGADDR = 5
) (
  input  logic [REGADDR-1:0] src,
  input  logic               exmem_regwrite,
  input  logic [REGADDR-1:0] exmem_rd,
  input  logic               memwb_regwrite,
  input  logic [REGADDR-1:0] memwb_rd,
  output fwd_sel_e           sel
);

  logic exmem_hit, memwb_hit;

  assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    sel = FWD_REG;
    if (exmem_hit)      sel = FWD_EXMEM;
    else if (memwb_hit) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage feeding the ALU: registered operands, decoded ALU control,
// flush/stall/bubble handling. Define ID_EX_FORWARD_EN for EX/MEM and MEM/WB forwarding.
module id_ex_alu_issue
  import mips_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallID,
  input  logic               FlushID,
  input  logic               ValidIn,
  input  logic [1:0]         ALUOpIn,
  input  logic [5:0]         FunctIn,
  input  logic               ALUSrcIn,
  input  logic               RegWriteIn,
  input  logic               BranchIn,
  input  logic [WIDTH-1:0]   RsData,
  input  logic [WIDTH-1:0]   RtData,
  input  logic [WIDTH-1:0]   ImmIn,
  input  logic [REGADDR-1:0] RsIn,
  input  logic [REGADDR-1:0] RtIn,
  input  logic [REGADDR-1:0] RdIn,
  input  logic               ExMemRegWrite,
  input  logic               MemWbRegWrite,
  input  logic [REGADDR-1:0] ExMemRd,
  input  logic [REGADDR-1:0] MemWbRd,
  input  logic [WIDTH-1:0]   ExMemResult,
  input  logic [WIDTH-1:0]   MemWbResult,
  output logic [WIDTH-1:0]   Operand1,
  output logic [WIDTH-1:0]   Operand2,
  output logic [1:0]         ALUControl,
  output logic               ValidEX,
  output logic               RegWriteEX,
  output logic               BranchEX,
  output logic [REGADDR-1:0] WriteRegEX,
  output logic [WIDTH-1:0]   StoreDataEX,
  output logic               IllegalFunct
);

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               branch;
    logic               alusrc;
    logic               illegal;
    alu_ctl_e           alu_ctl;
    logic [REGADDR-1:0] wreg;
    logic [REGADDR-1:0] rs;
    logic [REGADDR-1:0] rt;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
  } id_ex_t;

  id_ex_t   stage_q, load_d;
  alu_dec_t dec;
  logic     bubble;

  always_comb begin
    dec              = alu_decode(ALUOpIn, FunctIn);
    load_d           = '0;
    load_d.valid     = 1'b1;
    load_d.regwrite  = RegWriteIn & ~dec.illegal;
    load_d.branch    = BranchIn;
    load_d.alusrc    = ALUSrcIn;
    load_d.illegal   = dec.illegal;
    load_d.alu_ctl   = dec.ctl;
    load_d.wreg      = (ALUOpIn == OP_RTYPE) ? RdIn : RtIn;
    load_d.rs        = RsIn;
    load_d.rt        = RtIn;
    load_d.rs_data   = RsData;
    load_d.rt_data   = RtData;
    load_d.imm       = ImmIn;
  end

  // Flush beats stall; an unstalled load of a non-instruction is a bubble too.
  assign bubble = FlushID || (!StallID && !ValidIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stage_q <= '0;
    else if (bubble)   stage_q <= '0;
    else if (!StallID) stage_q <= load_d;
  end

  logic [WIDTH-1:0] rs_fwd, rt_fwd;

`ifdef ID_EX_FORWARD_EN
  fwd_sel_e rs_sel, rt_sel;

  forward_sel #(.REGADDR(REGADDR)) u_fwd_rs (
    .src            (stage_q.rs),
    .exmem_regwrite (ExMemRegWrite),
    .exmem_rd       (ExMemRd),
    .memwb_regwrite (MemWbRegWrite),
    .memwb_rd       (MemWbRd),
    .sel            (rs_sel)
  );

  forward_sel #(.REGADDR(REGADDR)) u_fwd_rt (
    .src            (stage_q.rt),
    .exmem_regwrite (ExMemRegWrite),
    .exmem_rd       (ExMemRd),
    .memwb_regwrite (MemWbRegWrite),
    .memwb_rd       (MemWbRd),
    .sel            (rt_sel)
  );

  assign rs_fwd = (rs_sel == FWD_EXMEM) ? ExMemResult :
                  (rs_sel == FWD_MEMWB) ? MemWbResult : stage_q.rs_data;
  assign rt_fwd = (rt_sel == FWD_EXMEM) ? ExMemResult :
                  (rt_sel == FWD_MEMWB) ? MemWbResult : stage_q.rt_data;
`else
  // Hazards are resolved by upstream stalls; forwarding ports are intentionally ignored.
  logic unused_fwd;
  assign unused_fwd = ^{ExMemRegWrite, MemWbRegWrite, ExMemRd, MemWbRd,
                        ExMemResult, MemWbResult, stage_q.rs, stage_q.rt};
  assign rs_fwd = stage_q.rs_data;
  assign rt_fwd = stage_q.rt_data;
`endif

  assign Operand1     = rs_fwd;
  assign Operand2     = stage_q.alusrc ? stage_q.imm : rt_fwd;
  assign StoreDataEX  = rt_fwd;
  assign ALUControl   = stage_q.alu_ctl;
  assign ValidEX      = stage_q.valid;
  assign RegWriteEX   = stage_q.regwrite & stage_q.valid;
  assign BranchEX     = stage_q.branch & stage_q.valid;
  assign WriteRegEX   = stage_q.wreg;
  assign IllegalFunct = stage_q.illegal & stage_q.valid;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: vector table, hand-written multi-cycle corners,
// and randomized traffic checked against a spec-level model.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallID, FlushID, ValidIn;
  logic [1:0]  ALUOpIn;
  logic [5:0]  FunctIn;
  logic        ALUSrcIn, RegWriteIn, BranchIn;
  logic [31:0] RsData, RtData, ImmIn;
  logic [4:0]  RsIn, RtIn, RdIn;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [31:0] ExMemResult, MemWbResult;
  logic [31:0] Operand1, Operand2, StoreDataEX;
  logic [1:0]  ALUControl;
  logic        ValidEX, RegWriteEX, BranchEX, IllegalFunct;
  logic [4:0]  WriteRegEX;

  id_ex_alu_issue #(.WIDTH(32), .REGADDR(5)) dut (
    .clk(clk), .rst(rst), .StallID(StallID), .FlushID(FlushID), .ValidIn(ValidIn),
    .ALUOpIn(ALUOpIn), .FunctIn(FunctIn), .ALUSrcIn(ALUSrcIn), .RegWriteIn(RegWriteIn),
    .BranchIn(BranchIn), .RsData(RsData), .RtData(RtData), .ImmIn(ImmIn),
    .RsIn(RsIn), .RtIn(RtIn), .RdIn(RdIn),
    .ExMemRegWrite(ExMemRegWrite), .MemWbRegWrite(MemWbRegWrite),
    .ExMemRd(ExMemRd), .MemWbRd(MemWbRd), .ExMemResult(ExMemResult), .MemWbResult(MemWbResult),
    .Operand1(Operand1), .Operand2(Operand2), .ALUControl(ALUControl), .ValidEX(ValidEX),
    .RegWriteEX(RegWriteEX), .BranchEX(BranchEX), .WriteRegEX(WriteRegEX),
    .StoreDataEX(StoreDataEX), .IllegalFunct(IllegalFunct)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid;
    bit [1:0]  op;
    bit [5:0]  funct;
    bit        alusrc, rw, br;
    bit [31:0] rsd, rtd, imm;
    bit [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct packed {
    bit        valid, rw, br, ill;
    bit [1:0]  ctl;
    bit [4:0]  wr;
    bit [31:0] op1, op2, st;
  } out_t;

  typedef struct packed {
    instr_t in;
    bit     stall, flush;
    out_t   exp;
  } row_t;

  instr_t cur, held;
  int     n_chk = 0;
  int     n_fail = 0;

  function automatic instr_t mk(bit [1:0] op, bit [5:0] funct, bit alusrc, bit rw, bit br,
                                bit [31:0] rsd, bit [31:0] rtd, bit [31:0] imm,
                                bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    instr_t i;
    i = '{valid: 1'b1, op: op, funct: funct, alusrc: alusrc, rw: rw, br: br,
          rsd: rsd, rtd: rtd, imm: imm, rs: rs, rt: rt, rd: rd};
    return i;
  endfunction

  function automatic out_t mo(bit v, bit [1:0] ctl, bit rw, bit br, bit ill, bit [4:0] wr,
                              bit [31:0] op1, bit [31:0] op2, bit [31:0] st);
    out_t o;
    o = '{valid: v, rw: rw, br: br, ill: ill, ctl: ctl, wr: wr, op1: op1, op2: op2, st: st};
    return o;
  endfunction

  // Forwarding as seen by EX: newest producer first, r0 is never a real producer.
  function automatic bit [31:0] fwd(bit [4:0] src, bit [31:0] regv);
`ifdef ID_EX_FORWARD_EN
    if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == src) return ExMemResult;
    if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == src) return MemWbResult;
`endif
    return regv;
  endfunction

  function automatic out_t model();
    out_t o;
    o = '0;
    if (!held.valid) return o;
    o.valid = 1'b1;
    case (held.op)
      2'd0: o.ctl = 2'd2;
      2'd1: o.ctl = 2'd3;
      2'd3: o.ctl = 2'd1;
      default:
        case (held.funct)
          6'h20: o.ctl = 2'd2;
          6'h22: o.ctl = 2'd3;
          6'h24: o.ctl = 2'd0;
          6'h25: o.ctl = 2'd1;
          default: begin o.ctl = 2'd2; o.ill = 1'b1; end
        endcase
    endcase
    o.rw  = held.rw && !o.ill;
    o.br  = held.br;
    o.wr  = (held.op == 2'd2) ? held.rd : held.rt;
    o.op1 = fwd(held.rs, held.rsd);
    o.st  = fwd(held.rt, held.rtd);
    o.op2 = held.alusrc ? held.imm : o.st;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".ValidEX"},      {31'd0, ValidEX},      {31'd0, e.valid});
    chk({tag, ".ALUControl"},   {30'd0, ALUControl},   {30'd0, e.ctl});
    chk({tag, ".RegWriteEX"},   {31'd0, RegWriteEX},   {31'd0, e.rw});
    chk({tag, ".BranchEX"},     {31'd0, BranchEX},     {31'd0, e.br});
    chk({tag, ".IllegalFunct"}, {31'd0, IllegalFunct}, {31'd0, e.ill});
    chk({tag, ".WriteRegEX"},   {27'd0, WriteRegEX},   {27'd0, e.wr});
    chk({tag, ".Operand1"},     Operand1,              e.op1);
    chk({tag, ".Operand2"},     Operand2,              e.op2);
    chk({tag, ".StoreDataEX"},  StoreDataEX,           e.st);
  endtask

  task automatic drive(input instr_t i, input bit stall, input bit flush);
    cur        = i;
    ValidIn    = i.valid;  ALUOpIn  = i.op;   FunctIn  = i.funct;
    ALUSrcIn   = i.alusrc; RegWriteIn = i.rw; BranchIn = i.br;
    RsData     = i.rsd;    RtData   = i.rtd;  ImmIn    = i.imm;
    RsIn       = i.rs;     RtIn     = i.rt;   RdIn     = i.rd;
    StallID    = stall;    FlushID  = flush;
  endtask

  task automatic set_fwd(input bit w1, input bit [4:0] d1, input bit [31:0] r1,
                         input bit w2, input bit [4:0] d2, input bit [31:0] r2);
    ExMemRegWrite = w1; ExMemRd = d1; ExMemResult = r1;
    MemWbRegWrite = w2; MemWbRd = d2; MemWbResult = r2;
  endtask

  // One rising edge: update the model from the stimulus present at the edge, then settle.
  task automatic step();
    @(posedge clk);
    if (FlushID)       held = '0;
    else if (!StallID) held = ValidIn ? cur : '0;
    #1;
  endtask

  row_t   vec[13];
  instr_t i0, i_v0, i_add;
  out_t   e0, zero_o;

  initial begin
    zero_o = '0;
    i0   = mk(2'd2, 6'h22, 1'b0, 1'b1, 1'b0, 32'd7, 32'd3, 32'd0, 5'd1, 5'd4, 5'd9);
    e0   = mo(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 5'd9, 32'd7, 32'd3, 32'd3);
    i_v0 = i0; i_v0.valid = 1'b0;
    i_add = mk(2'd2, 6'h20, 1'b0, 1'b1, 1'b0, 32'hF0, 32'h3C, 32'd0, 5'd1, 5'd2, 5'd7);

    vec[0]  = '{in: i0, stall: 0, flush: 0, exp: e0};
    vec[1]  = '{in: mk(2'd2, 6'h2A, 0, 1, 0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd10), stall: 0, flush: 0,
                exp: mo(1, 2'd2, 0, 0, 1, 5'd10, 32'd1, 32'd2, 32'd2)};
    vec[2]  = '{in: mk(2'd0, 6'h00, 1, 1, 0, 32'h10, 32'h99, 32'hFFFFFFFC, 5'd3, 5'd6, 5'd12), stall: 0, flush: 0,
                exp: mo(1, 2'd2, 1, 0, 0, 5'd6, 32'h10, 32'hFFFFFFFC, 32'h99)};
    vec[3]  = '{in: mk(2'd1, 6'h00, 0, 0, 1, 32'd20, 32'd20, 32'd0, 5'd1, 5'd2, 5'd3), stall: 0, flush: 0,
                exp: mo(1, 2'd3, 0, 1, 0, 5'd2, 32'd20, 32'd20, 32'd20)};
    vec[4]  = '{in: mk(2'd3, 6'h00, 1, 1, 0, 32'h1200, 32'd5, 32'hFFFF, 5'd4, 5'd8, 5'd0), stall: 0, flush: 0,
                exp: mo(1, 2'd1, 1, 0, 0, 5'd8, 32'h1200, 32'hFFFF, 32'd5)};
    vec[5]  = '{in: mk(2'd2, 6'h24, 0, 1, 0, 32'hF0, 32'h3C, 32'd0, 5'd1, 5'd2, 5'd7), stall: 0, flush: 0,
                exp: mo(1, 2'd0, 1, 0, 0, 5'd7, 32'hF0, 32'h3C, 32'h3C)};
    vec[6]  = '{in: mk(2'd2, 6'h25, 0, 1, 0, 32'hF0, 32'h3C, 32'd0, 5'd1, 5'd2, 5'd7), stall: 0, flush: 0,
                exp: mo(1, 2'd1, 1, 0, 0, 5'd7, 32'hF0, 32'h3C, 32'h3C)};
    vec[7]  = '{in: i_add, stall: 0, flush: 0,
                exp: mo(1, 2'd2, 1, 0, 0, 5'd7, 32'hF0, 32'h3C, 32'h3C)};
    vec[8]  = '{in: i0, stall: 0, flush: 1, exp: zero_o};
    vec[9]  = '{in: i0, stall: 0, flush: 0, exp: e0};
    vec[10] = '{in: i_add, stall: 1, flush: 1, exp: zero_o};
    vec[11] = '{in: i0, stall: 0, flush: 0, exp: e0};
    vec[12] = '{in: i_v0, stall: 0, flush: 0, exp: zero_o};

    // Reset state before any clock edge
    held = '0;
    rst  = 1'b1;
    drive('0, 1'b0, 1'b0);
    set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #2;
    check_out("reset", zero_o);
    #1 rst = 1'b0;

    foreach (vec[k]) begin
      drive(vec[k].in, vec[k].stall, vec[k].flush);
      step();
      check_out($sformatf("vec%0d", k), vec[k].exp);
    end

    // Stall holds for three edges while ID presents something else
    drive(vec[5].in, 0, 0);
    step();
    drive(i0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out($sformatf("stall%0d", c), vec[5].exp);
    end
    drive(i0, 0, 0);
    step();
    check_out("stall_release", e0);

    // Asynchronous reset while stalled on a valid add
    drive(i_add, 0, 0);
    step();
    drive(i0, 1, 0);
    step();
    #2 rst = 1'b1;
    held = '0;
    #1;
    check_out("rst_mid_stall", zero_o);
    #1 rst = 1'b0;
    step();
    check_out("rst_then_stall", zero_o);

    // Forwarding corners: double match, MEM/WB only, r0, and a store with forwarded Rt
    drive(mk(2'd0, 6'h00, 0, 1, 0, 32'hAA, 32'hBB, 32'd0, 5'd5, 5'd7, 5'd1), 0, 0);
    step();
    set_fwd(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
    #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd_exmem_wins", Operand1, 32'h11);
`else
    chk("fwd_exmem_wins", Operand1, 32'hAA);
`endif
    ExMemRegWrite = 1'b0;
    #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd_memwb", Operand1, 32'h22);
`else
    chk("fwd_memwb", Operand1, 32'hAA);
`endif
    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    drive(mk(2'd0, 6'h00, 0, 1, 0, 32'h33, 32'hBB, 32'd0, 5'd0, 5'd7, 5'd1), 0, 0);
    step();
    chk("fwd_r0", Operand1, 32'h33);
    set_fwd(1, 5'd6, 32'h99, 0, 5'd0, 32'd0);
    drive(mk(2'd0, 6'h00, 1, 1, 0, 32'h10, 32'h44, 32'hFFFFFFFC, 5'd3, 5'd6, 5'd12), 0, 0);
    step();
    chk("imm_op2", Operand2, 32'hFFFFFFFC);
    chk("imm_ctl", {30'd0, ALUControl}, 32'd2);
`ifdef ID_EX_FORWARD_EN
    chk("store_fwd", StoreDataEX, 32'h99);
`else
    chk("store_fwd", StoreDataEX, 32'h44);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      instr_t r;
      bit [5:0] fsel[5];
      fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'($urandom)};
      r = mk(2'($urandom), fsel[$urandom_range(0, 4)], 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      r.valid = ($urandom_range(0, 3) != 0);
      drive(r, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        held = '0;
        #1 check_out("rand_rst", model());
        rst = 1'b0;
      end
      step();
      check_out("rand_edge", model());
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      #1;
      check_out("rand_fwd", model());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
ID/EX pipeline stage for the operand-producing side of the ALU interface. It registers decoded operands and control from ID. Each cycle it presents Operand1, Operand2 and the 2-bit ALUControl to the EX-stage ALU. Stall, flush and bubble handling live here, and optional EX/MEM and MEM/WB forwarding muxes select the final operands.

Parameters:
WIDTH, 32, datapath width of operands and immediate
REGADDR, 5, register-specifier width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
StallID  in  1  hold current ID/EX contents
FlushID  in  1  load a bubble into ID/EX
ValidIn  in  1  ID holds a real instruction
ALUOpIn  in  2  main-control ALU op: 00 add, 01 sub, 10 R-type, 11 or-immediate
FunctIn  in  6  instruction funct field
ALUSrcIn  in  1  1: Operand2 = immediate
RegWriteIn  in  1  instruction writes the register file
BranchIn  in  1  instruction is beq
RsData, RtData  in  WIDTH  register-file read data
ImmIn  in  WIDTH  sign- or zero-extended immediate from ID
RsIn, RtIn, RdIn  in  REGADDR  register specifiers
ExMemRegWrite, MemWbRegWrite  in  1  write enables of later stages
ExMemRd, MemWbRd  in  REGADDR  destination registers of later stages
ExMemResult, MemWbResult  in  WIDTH  forwardable results
Operand1, Operand2  out  WIDTH  ALU operands
ALUControl  out  2  00 AND, 01 OR, 10 ADD, 11 SUB
ValidEX, RegWriteEX, BranchEX  out  1  registered control, gated by valid
WriteRegEX  out  REGADDR  destination: RdIn if ALUOp==10, else RtIn
StoreDataEX  out  WIDTH  forwarded Rt value for stores
IllegalFunct  out  1  registered: R-type with unsupported funct

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - all stage registers clear to 0;
  - ValidEX, RegWriteEX, BranchEX, IllegalFunct = 0;
  - ALUControl = 00;
  - Operand1/Operand2 = 0 when no forwarding matches.
- Update priority at each rising clk edge: FlushID > StallID > load.
- Flush: valid, RegWrite, Branch and IllegalFunct are cleared and ALUControl is forced to 00. The data registers may be don't-care, but the implementation zeroes them.
- Stall (no flush): every register holds. Forwarding muxes still re-evaluate each cycle.
- Load: when ValidIn=0, the load behaves as a flush.
- Latency: ID inputs appear at outputs one cycle after the loading edge.
- Decode is registered. ALUControl is stored, not recomputed in EX.
  - ALUOp 00 → 10 (ADD)
  - ALUOp 01 → 11 (SUB)
  - ALUOp 11 → 01 (OR)
  - ALUOp 10 with funct 100000 → 10 (ADD)
  - funct 100010 → 11 (SUB)
  - funct 100100 → 00 (AND)
  - funct 100101 → 01 (OR)
  - any other funct → 10 (ADD), IllegalFunct=1, RegWriteEX=0
- Forward select per source (Rs, Rt), evaluated combinationally from registered specifiers:
  - EX/MEM if ExMemRegWrite && ExMemRd!=0 && ExMemRd==src;
  - else MEM/WB under the same test;
  - else registered data;
  - EX/MEM wins on double match;
  - register 0 never forwards.
- Operand1 = forwarded Rs.
- Operand2 = registered ImmIn if ALUSrc, else forwarded Rt.
- StoreDataEX = forwarded Rt.
- All outputs are qualified: RegWriteEX = RegWrite & ValidEX; BranchEX = Branch & ValidEX.
- Simultaneous StallID and FlushID: flush wins.
- Width: all arithmetic is external. There is no truncation, and ImmIn is passed as-is.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - Operand1 = registered RsData; Operand2 and StoreDataEX come from registered data only;
  - forwarding ports remain but are ignored;
  - hazard resolution is left to stalls upstream.

Decomposition:
- Shared package mips_alu_pkg holds:
  - ALUControl codes AND/OR/ADD/SUB;
  - ALUOp codes;
  - funct constants;
  - forward-select encoding (00 reg, 01 MEM/WB, 10 EX/MEM).
- One sub-module, forward_sel: computes the 2-bit select for one source specifier. It is instantiated twice, only under ID_EX_FORWARD_EN.

Test Plan:
- Reset asserted mid-stall with valid add loaded → outputs immediately ValidEX=0, ALUControl=00, RegWriteEX=0.
- ALUOp=10, funct=100010, RsData=7, RtData=3, ALUSrc=0, one edge → ALUControl=11, Operand1=7, Operand2=3, WriteRegEX=RdIn.
- ALUOp=10, funct=101010 → ALUControl=10, IllegalFunct=1, RegWriteEX=0.
- StallID=1 and FlushID=1 together with a valid instruction → next cycle ValidEX=0; StallID alone over 3 cycles → outputs constant.
- Forwarding on, RsIn=5, ExMemRd=5 (RegWrite=1, Result=0x11), MemWbRd=5 (Result=0x22) → Operand1=0x11; ExMemRegWrite=0 → Operand1=0x22; Rs=0 → registered data.
- ALUOp=00, ALUSrc=1, Imm=0xFFFFFFFC, Rt forwarded 0x99 → Operand2=0xFFFFFFFC, StoreDataEX=0x99, ALUControl=10.
